// File: rtl/seq_00110_framer.sv
// Serial frame transmitter: sync word, MSB-first payload, optional even parity, idle-high gap.
// Optional parity bit is enabled by defining SEQ_FRAMER_PARITY_EN.
module seq_00110_framer #(
    parameter int                DATA_W  = 8,
    parameter int                SYNC_W  = 5,
    parameter logic [SYNC_W-1:0] SYNC    = 5'b00110,
    parameter int                GAP_LEN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              sout,
    output logic              busy,
    output logic              frame_valid,
    output logic              done
);

    localparam int MAX_SD = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAX_W  = (MAX_SD > GAP_LEN) ? MAX_SD : GAP_LEN;
    localparam int CW     = $clog2(MAX_W) + 1;

`ifdef SEQ_FRAMER_PARITY_EN
    localparam int FW = SYNC_W + DATA_W + 1;
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_PAR, ST_GAP} state_t;
`else
    localparam int FW = SYNC_W + DATA_W;
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_GAP} state_t;
`endif

    state_t          state;
    logic [FW-1:0]   frame_sr;
    logic [FW-1:0]   frame_load;
    logic [CW-1:0]   cnt;
    logic            frame_end;
    logic            gap_end;
    logic            release_now;

`ifdef SEQ_FRAMER_PARITY_EN
    assign frame_load = {SYNC, din, ^din};
`else
    assign frame_load = {SYNC, din};
`endif

    // release_now marks every edge where a new start may be accepted: idle, end of gap,
    // or end of frame when there is no gap (back-to-back frames).
    always_comb begin
`ifdef SEQ_FRAMER_PARITY_EN
        frame_end = (state == ST_PAR);
`else
        frame_end = (state == ST_DATA) && (cnt == CW'(DATA_W));
`endif
        gap_end     = (GAP_LEN > 0) && (state == ST_GAP) && (cnt == CW'(GAP_LEN - 1));
        release_now = (state == ST_IDLE) || gap_end || ((GAP_LEN == 0) && frame_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sout        <= 1'b1;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            done        <= 1'b0;
            frame_sr    <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_SYNC: begin
                    sout     <= frame_sr[FW-1];
                    frame_sr <= frame_sr << 1;
                    if (cnt == CW'(SYNC_W)) begin
                        state <= ST_DATA;
                        cnt   <= CW'(1);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt != CW'(DATA_W)) begin
                        sout     <= frame_sr[FW-1];
                        frame_sr <= frame_sr << 1;
                        cnt      <= cnt + 1'b1;
                    end
`ifdef SEQ_FRAMER_PARITY_EN
                    else begin
                        state    <= ST_PAR;
                        sout     <= frame_sr[FW-1];
                        frame_sr <= frame_sr << 1;
                    end
`endif
                end
                ST_GAP:  cnt <= cnt + 1'b1;
                ST_IDLE: ;
                default: state <= ST_IDLE;
            endcase

            if (frame_end) begin
                sout        <= 1'b1;
                frame_valid <= 1'b0;
                done        <= 1'b1;
                state       <= ST_GAP;
                cnt         <= '0;
            end

            // Later assignments win, so acceptance overrides the end-of-frame/gap updates.
            if (release_now) begin
                if (start) begin
                    state       <= ST_SYNC;
                    sout        <= frame_load[FW-1];
                    frame_sr    <= frame_load << 1;
                    cnt         <= CW'(1);
                    busy        <= 1'b1;
                    frame_valid <= 1'b1;
                end else begin
                    state       <= ST_IDLE;
                    sout        <= 1'b1;
                    busy        <= 1'b0;
                    frame_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_00110_framer.sv
// Scoreboard bench for seq_00110_framer (GAP_LEN=2 instance plus a GAP_LEN=0 loopback instance).
module tb_seq_00110_framer;

    localparam int         DATA_W    = 8;
    localparam int         SYNC_W    = 5;
    localparam int         GAP_LEN   = 2;
    localparam logic [4:0] SYNC_WORD = 5'b00110;
`ifdef SEQ_FRAMER_PARITY_EN
    localparam int         F = SYNC_W + DATA_W + 1;
`else
    localparam int         F = SYNC_W + DATA_W;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              start0 = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] din0 = '0;
    logic              sout, busy, frame_valid, done;
    logic              sout0, busy0, frame_valid0, done0;

    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [3:0]  sb[$];
    logic [4:0]  hist;

    always #5 clk = ~clk;

    seq_00110_framer #(
        .DATA_W (DATA_W),
        .SYNC_W (SYNC_W),
        .SYNC   (SYNC_WORD),
        .GAP_LEN(GAP_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din        (din),
        .sout       (sout),
        .busy       (busy),
        .frame_valid(frame_valid),
        .done       (done)
    );

    seq_00110_framer #(
        .DATA_W (DATA_W),
        .SYNC_W (SYNC_W),
        .SYNC   (SYNC_WORD),
        .GAP_LEN(0)
    ) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start0),
        .din        (din0),
        .sout       (sout0),
        .busy       (busy0),
        .frame_valid(frame_valid0),
        .done       (done0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Expected bit stream of a frame: sync, payload MSB-first, optional even parity.
    function automatic logic [15:0] frame_of(input logic [7:0] d);
`ifdef SEQ_FRAMER_PARITY_EN
        return {2'b00, SYNC_WORD, d, ^d};
`else
        return {3'b000, SYNC_WORD, d};
`endif
    endfunction

    // Entries are {sout, frame_valid, busy, done}, one per cycle starting at the accept edge.
    task automatic push_frame(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) sb.push_back({bits[i], 3'b110});
        sb.push_back(4'b1011);
        for (int i = 1; i < GAP_LEN; i++) sb.push_back(4'b1010);
    endtask

    task automatic step(input string tag);
        logic [3:0] e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(tag, {28'd0, sout, frame_valid, busy, done}, {28'd0, e});
        end
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            sb.push_back(4'b1000);
            step(tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [12:0] a5_lit;
        logic [15:0] a5_frame;
        a5_lit = 13'b0011010100101;
`ifdef SEQ_FRAMER_PARITY_EN
        a5_frame = {2'b00, a5_lit, 1'b0};
`else
        a5_frame = {3'b000, a5_lit};
`endif

        repeat (3) @(negedge clk);
        check("reset_state", {28'd0, sout, frame_valid, busy, done}, 32'h8);
        rst_n = 1'b1;

        idle(20, "idle20");

        // Single frame of A5 against the literal bit pattern.
        push_frame(a5_frame, F);
        start = 1'b1; din = 8'hA5;
        step("a5_frame");
        start = 1'b0; din = 8'h00;
        repeat (F + GAP_LEN - 1) step("a5_frame");
        idle(3, "a5_after");

        // Odd-weight payload (parity bit 1 when enabled).
        push_frame(frame_of(8'h01), F);
        start = 1'b1; din = 8'h01;
        step("d01_frame");
        start = 1'b0;
        repeat (F + GAP_LEN - 1) step("d01_frame");
        idle(2, "d01_after");

        // start held through a frame with din changing: first frame intact, second at busy fall.
        push_frame(frame_of(8'h3C), F);
        push_frame(frame_of(8'hC3), F);
        start = 1'b1; din = 8'h3C;
        step("held_first");
        din = 8'hC3;
        repeat (F + GAP_LEN - 1) step("held_first");
        step("held_second");
        start = 1'b0; din = 8'h00;
        repeat (F + GAP_LEN - 1) step("held_second");
        idle(3, "held_after");

        // Asynchronous reset in the middle of the payload.
        push_frame(frame_of(8'hA5), F);
        start = 1'b1; din = 8'hA5;
        step("abort_frame");
        start = 1'b0;
        repeat (7) step("abort_frame");
        sb.delete();
        #2 rst_n = 1'b0;
        #1 check("async_reset", {28'd0, sout, frame_valid, busy, done}, 32'h8);
        @(negedge clk);
        check("reset_hold", {28'd0, sout, frame_valid, busy, done}, 32'h8);
        rst_n = 1'b1;
        idle(4, "no_done_after_abort");
        push_frame(frame_of(8'h5A), F);
        start = 1'b1; din = 8'h5A;
        step("post_reset_frame");
        start = 1'b0;
        repeat (F + GAP_LEN - 1) step("post_reset_frame");
        idle(2, "post_reset_after");

        // Zero-gap loopback into a 00110 detector model: one detect per frame, done between frames.
        hist = 5'b11111;
        start0 = 1'b1; din0 = 8'hFF;
        for (int off = 0; off < 3 * F; off++) begin
            @(negedge clk);
            hist = {hist[3:0], sout0};
            check("zero_gap_loop",
                  {28'd0, hist == 5'b00110, done0, frame_valid0, busy0},
                  {28'd0, (off % F) == 4, (off > 0) && ((off % F) == 0), 2'b11});
        end
        start0 = 1'b0;
        repeat (F + 2) @(negedge clk);
        check("zero_gap_idle", {28'd0, sout0, frame_valid0, busy0, done0}, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
